// File: rtl/keyb_scan_ctrl_if.sv
// Keypad-side signal bundle for the keypad scan controller.
// slave  : the scan controller (samples rows, drives columns and key outputs)
// master : the keypad/decoder side (drives rows and scan enable)
interface keyb_scan_ctrl_if;
  logic       scan_en;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output scan_en, row_n,
    input  col_n, key_code, key_valid, key_held
  );

  modport slave (
    input  scan_en, row_n,
    output col_n, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keyb_scan_ctrl.sv
// 4x4 membrane keypad scanner with press and release debounce.
// One column is driven low at a time; rows come in through a 2-FF
// synchronizer. A captured key freezes the column until it is fully released.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_SCAN     | dwell on a column, capture lowest low row at terminal count
//   ST_DEBOUNCE | captured row must stay low for DB_CYC cycles to be accepted
//   ST_HELD     | key accepted and still pressed, column frozen
//   ST_RELEASE  | row went high, must stay high DB_CYC cycles to finish
module keyb_scan_ctrl #(
  parameter int FREQ_HZ     = 12000000,
  parameter int SCAN_US     = 100,
  parameter int DEBOUNCE_MS = 1,
  parameter int CNT_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  keyb_scan_ctrl_if.slave   kbd
);

  localparam int SCAN_CYC = (FREQ_HZ / 1000000) * SCAN_US;
  localparam int DB_CYC   = (FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam logic [CNT_W-1:0] SCAN_RLD = CNT_W'(SCAN_CYC - 1);
  localparam logic [CNT_W-1:0] DB_RLD   = CNT_W'(DB_CYC - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [3:0]       row_meta_q, row_s_q;
  logic [1:0]       row_lo;
  logic             cnt_zero;
  logic             row_up;

  // Bring the asynchronous row lines into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'b1111;
      row_s_q    <= 4'b1111;
    end else begin
      row_meta_q <= kbd.row_n;
      row_s_q    <= row_meta_q;
    end
  end

  // Lowest-index low row wins when several keys share the active column.
  always_comb begin
    row_lo = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_q[i]) row_lo = 2'(i);
    end
  end

  assign cnt_zero = (cnt_q == '0);
  assign row_up   = row_s_q[row_idx_q];

  // Next-state, shared counter and key output decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      ST_SCAN: begin
        if (kbd.scan_en) begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (row_s_q != 4'b1111) begin
            row_idx_d = row_lo;
            cnt_d     = DB_RLD;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            cnt_d     = SCAN_RLD;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (row_up) begin
          col_idx_d = col_idx_q + 2'd1;
          cnt_d     = SCAN_RLD;
          state_d   = ST_SCAN;
        end else if (cnt_zero) begin
          key_code_d  = {row_idx_q, col_idx_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          cnt_d       = DB_RLD;
          state_d     = ST_HELD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (row_up) begin
          cnt_d   = DB_RLD;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!row_up) begin
          cnt_d   = DB_RLD;
          state_d = ST_HELD;
        end else if (cnt_zero) begin
          key_held_d = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
          cnt_d      = SCAN_RLD;
          state_d    = ST_SCAN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = SCAN_RLD;
        state_d = ST_SCAN;
      end
    endcase
    col_n_d = ~(4'b0001 << col_idx_d);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      cnt_q       <= SCAN_RLD;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      row_idx_q   <= 2'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      col_n_q     <= col_n_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kbd.col_n     = col_n_q;
  assign kbd.key_code  = key_code_q;
  assign kbd.key_valid = key_valid_q;
  assign kbd.key_held  = key_held_q;

endmodule

// File: tb/tb_keyb_scan_ctrl.sv
// Bench for keyb_scan_ctrl: a 4x4 keypad matrix model drives the rows from the
// driven column; checks are made at the level of key events (one strobe per
// press, code, latency window, release hold time, column freeze/advance).
module tb_keyb_scan_ctrl;
  localparam int SCAN  = 4;
  localparam int DB    = 1000;
  localparam int BOUND = 4 * SCAN + DB + 3;
  localparam int REL   = DB + 3;   // debounce + 2 sync stages + output register

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys;               // keys[r*4+c] = key at row r, column c pressed
  logic [3:0]  row_drive;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0, valid_cnt = 0, valid_cyc = 0, held_fall_cyc = 0;
  int dbl_strobe = 0, bad_col = 0, frozen_viol = 0;
  logic [3:0] last_code = 4'd0;
  logic prev_valid = 1'b0, prev_held = 1'b0;
  logic [3:0] prev_col = 4'b1110;

  keyb_scan_ctrl_if kbd ();

  keyb_scan_ctrl #(
    .FREQ_HZ(1000000), .SCAN_US(4), .DEBOUNCE_MS(1), .CNT_W(24)
  ) dut (
    .clk(clk), .reset(reset), .kbd(kbd)
  );

  always #5 clk = ~clk;

  // Membrane matrix: a pressed key shorts its row to the driven-low column.
  always_comb begin
    row_drive = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kbd.col_n[c]) row_drive[r] = 1'b0;
  end
  assign kbd.row_n = row_drive;

  // Event monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (kbd.key_valid === 1'b1) begin
      valid_cnt++;
      last_code = kbd.key_code;
      valid_cyc = cyc;
      if (prev_valid) dbl_strobe++;
    end
    if (prev_held && kbd.key_held === 1'b0) held_fall_cyc = cyc;
    if (!(kbd.col_n inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad_col++;
    if (prev_held && kbd.key_held === 1'b1 && kbd.col_n !== prev_col) frozen_viol++;
    prev_valid = kbd.key_valid;
    prev_held  = kbd.key_held;
    prev_col   = kbd.col_n;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_in(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (c % 4));
  endfunction

  task automatic wait_held_low();
    int k;
    k = 0;
    while (kbd.key_held !== 1'b0 && k < 1200) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Press the keys in mask (all in column col), hold, release, judge the event.
  task automatic press_cycle(input string tag, input logic [15:0] mask, input int hold,
                             input logic accept, input logic [3:0] code, input int col);
    int v0, t0, tr;
    v0 = valid_cnt;
    keys = mask;
    t0 = cyc;
    repeat (hold) @(negedge clk);
    chk({tag, "_col_frozen"}, 32'(kbd.col_n), 32'(col_pat(col)));
    chk({tag, "_held_pre"}, 32'(kbd.key_held), 32'(accept));
    keys = 16'h0;
    tr = cyc;
    if (accept) begin
      wait_held_low();
      chk_in({tag, "_release_time"}, held_fall_cyc - tr, REL, REL);
      chk({tag, "_code"}, 32'(last_code), 32'(code));
      chk_in({tag, "_latency"}, valid_cyc - t0, DB, BOUND);
    end else begin
      repeat (4) @(negedge clk);
      chk({tag, "_held_post"}, 32'(kbd.key_held), 32'd0);
    end
    chk({tag, "_col_next"}, 32'(kbd.col_n), 32'(col_pat(col + 1)));
    chk({tag, "_strobes"}, 32'(valid_cnt - v0), accept ? 32'd1 : 32'd0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int idx, k, v0, t0, tr, r, c, r2, hold;
    logic [3:0] c0;
    logic [15:0] m;

    // Reset values
    reset = 1'b1;
    keys = 16'h0;
    kbd.scan_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col_n", 32'(kbd.col_n), 32'hE);
    chk("rst_key_code", 32'(kbd.key_code), 32'h0);
    chk("rst_key_valid", 32'(kbd.key_valid), 32'h0);
    chk("rst_key_held", 32'(kbd.key_held), 32'h0);
    reset = 1'b0;

    // Idle scanning: each column for exactly SCAN cycles, in rotation
    c0 = kbd.col_n;
    k = 0;
    while (kbd.col_n === c0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    idx = 0;
    for (int i = 0; i < 4; i++) if (kbd.col_n[i] === 1'b0) idx = i;
    for (int n = 0; n < 4 * SCAN * 2; n++) begin
      chk($sformatf("idle_col_%0d", n), 32'(kbd.col_n), 32'(col_pat(idx + n / SCAN)));
      @(negedge clk);
    end
    chk("idle_no_valid", 32'(valid_cnt), 32'd0);
    chk("idle_no_held", 32'(kbd.key_held), 32'd0);

    // Directed: row2/col1 held 2000 cycles
    press_cycle("r2c1", 16'h1 << 9, 2000, 1'b1, 4'b1001, 1);
    // Directed: row1/col3 shorter than debounce
    press_cycle("r1c3_short", 16'h1 << 7, 300, 1'b0, 4'b0000, 3);
    // Directed: rows 1 and 3 in col2 together, lowest row wins
    press_cycle("r1r3c2", (16'h1 << 6) | (16'h1 << 14), 1500, 1'b1, 4'b0110, 2);

    // Directed: release bounce on row0/col0
    v0 = valid_cnt;
    keys = 16'h0001;
    t0 = cyc;
    repeat (1200) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      keys = keys ^ 16'h0001;
      repeat (50) @(negedge clk);
    end
    chk("bounce_held_through", 32'(kbd.key_held), 32'd1);
    keys = 16'h0;
    tr = cyc;
    wait_held_low();
    chk_in("bounce_release_time", held_fall_cyc - tr, REL, REL);
    chk("bounce_strobes", 32'(valid_cnt - v0), 32'd1);
    chk("bounce_code", 32'(last_code), 32'h0);
    chk_in("bounce_latency", valid_cyc - t0, DB, BOUND);
    repeat (10) @(negedge clk);

    // Random single keys and same-column pairs, long or short presses
    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(3, 0);
      c = $urandom_range(3, 0);
      m = 16'h1 << (r * 4 + c);
      if ($urandom_range(1, 0) == 1) begin
        r2 = $urandom_range(3, 0);
        m = m | (16'h1 << (r2 * 4 + c));
        if (r2 < r) r = r2;
      end
      if ($urandom_range(2, 0) != 0) begin
        hold = $urandom_range(1600, 1100);
        press_cycle($sformatf("rnd%0d_long", it), m, hold, 1'b1, 4'(r * 4 + c), c);
      end else begin
        hold = $urandom_range(600, 100);
        press_cycle($sformatf("rnd%0d_short", it), m, hold, 1'b0, 4'h0, c);
      end
    end

    // scan_en low freezes scanning and blocks capture
    kbd.scan_en = 1'b0;
    @(negedge clk);
    c0 = kbd.col_n;
    r = $urandom_range(3, 0);
    c = $urandom_range(3, 0);
    v0 = valid_cnt;
    keys = 16'h1 << (r * 4 + c);
    repeat (200) @(negedge clk);
    chk("freeze_col", 32'(kbd.col_n), 32'(c0));
    chk("freeze_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("freeze_no_held", 32'(kbd.key_held), 32'd0);
    kbd.scan_en = 1'b1;
    t0 = cyc;
    repeat (BOUND + 5) @(negedge clk);
    chk("unfreeze_strobes", 32'(valid_cnt - v0), 32'd1);
    chk("unfreeze_code", 32'(last_code), 32'(r * 4 + c));
    chk_in("unfreeze_latency", valid_cyc - t0, DB, BOUND);
    keys = 16'h0;
    wait_held_low();
    repeat (10) @(negedge clk);

    // Reset in the middle of debounce, key kept pressed
    r = $urandom_range(3, 0);
    c = $urandom_range(3, 0);
    v0 = valid_cnt;
    keys = 16'h1 << (r * 4 + c);
    repeat (500) @(negedge clk);
    chk("mid_db_no_valid", 32'(valid_cnt - v0), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_db_rst_col", 32'(kbd.col_n), 32'hE);
    chk("mid_db_rst_held", 32'(kbd.key_held), 32'd0);
    chk("mid_db_rst_valid", 32'(kbd.key_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
    repeat (BOUND + 5) @(negedge clk);
    chk("post_rst_strobes", 32'(valid_cnt - v0), 32'd1);
    chk("post_rst_code", 32'(last_code), 32'(r * 4 + c));
    chk_in("post_rst_latency", valid_cyc - t0, DB, BOUND);
    chk("post_rst_held", 32'(kbd.key_held), 32'd1);
    keys = 16'h0;
    tr = cyc;
    wait_held_low();
    chk_in("post_rst_release_time", held_fall_cyc - tr, REL, REL);
    chk("post_rst_total_strobes", 32'(valid_cnt - v0), 32'd1);
    repeat (10) @(negedge clk);

    // Whole-run invariants
    chk("single_cycle_strobe", 32'(dbl_strobe), 32'd0);
    chk("col_one_low", 32'(bad_col), 32'd0);
    chk("col_frozen_while_held", 32'(frozen_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/keyb_scan_ctrl.md
Name: keyb_scan_ctrl

Overview:
Scan controller for the calculator's 4x4 membrane keypad. It drives the column lines one at a time and samples the row lines through a synchronizer. It debounces both press and release on the captured key and emits one registered key code with a single-cycle valid strobe per physical press. It sits between the keypad pins and the calculator's key decoder/FSM, replacing the free-running scan plus separate antibounce path.

Parameters:
FREQ_HZ, 12000000, system clock frequency in Hz
SCAN_US, 100, dwell time per column in microseconds; SCAN_CYC = (FREQ_HZ/1000000)*SCAN_US
DEBOUNCE_MS, 1, press and release debounce time in ms; DB_CYC = (FREQ_HZ/1000)*DEBOUNCE_MS
CNT_W, 24, width of the shared down-counter; must satisfy 2^CNT_W > max(SCAN_CYC, DB_CYC)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
scan_en  input  1  1 = scanning allowed; 0 = freeze in SCAN, with no new captures
row_n  input  4  keypad rows, active-low (external pull-ups), asynchronous to clk
col_n  output  4  column drive, active-low, exactly one bit low at all times
key_code  output  4  {row_idx[1:0], col_idx[1:0]} of last accepted key, held until the next accept
key_valid  output  1  one-cycle strobe when a debounced press is accepted
key_held  output  1  high while the accepted key remains pressed (states HELD and RELEASE)

Behaviour:
- Reset (async, any state): state=SCAN, col_idx=0, col_n=4'b1110, key_code=0, key_valid=0, key_held=0, counter=SCAN_CYC-1, synchronizer FFs=4'b1111.
- row_n passes through a 2-FF synchronizer to give row_s. All decisions use row_s only.
- col_n = ~(4'b0001 << col_idx), registered. It changes only on a column advance.
- SCAN:
  - Counter decrements each cycle while scan_en=1. When scan_en=0, the counter holds and no capture occurs.
  - At counter==0:
    - If any row_s bit is 0, capture row_idx = lowest-index low row, load counter=DB_CYC-1, and go to DEBOUNCE. The column is held.
    - Otherwise, col_idx = col_idx+1 (3 wraps to 0) and reload SCAN_CYC-1.
  - Dwell ≥ 3 cycles is guaranteed by parameter choice; this covers synchronizer latency after a column change.
- DEBOUNCE:
  - If row_s[row_idx]=1 on any cycle (bounce or release), abort: advance the column, reload SCAN_CYC-1, go to SCAN. No strobe.
  - At counter==0 with row_s[row_idx]=0: key_code <= {row_idx, col_idx}, key_valid=1 for exactly one cycle, key_held=1, go to HELD.
- HELD:
  - Column stays frozen; scan_en is ignored.
  - When row_s[row_idx]=1, load DB_CYC-1 and go to RELEASE.
- RELEASE:
  - If row_s[row_idx]=0 again, go back to HELD. Release bounce produces no new key_valid.
  - At counter==0 with the row still high: key_held=0, advance the column, reload SCAN_CYC-1, go to SCAN.
- Latency: key_valid asserts at most 4*SCAN_CYC + DB_CYC + 3 cycles after a stable press begins. It never asserts twice for one press.
- Multiple keys: in the active column, the lowest row wins. Keys in other columns and other rows are ignored until full release.
- Counter is a single CNT_W-bit down-counter shared by all states and reloaded on every state entry.
- Reset mid-DEBOUNCE or mid-HELD: immediate return to reset values. A key still held after reset is re-detected and reported once.

Test Plan:
(Test parameters: FREQ_HZ=1000000, SCAN_US=4 (4 cycles), DEBOUNCE_MS=1 (1000 cycles).)
- No key pressed, scan_en=1 -> col_n cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid never asserts; key_held=0.
- Key row2/col1 held low for 2000 cycles -> exactly one key_valid with key_code=4'b1001; key_held=1 until 1000 cycles after release; col_n stays 1101 throughout.
- Row1/col3 pressed for 300 cycles (shorter than debounce), then released -> no key_valid; scanning resumes at col 0.
- Stable press on row0/col0, then at release row_n toggles every 50 cycles for 400 cycles before settling high -> single key_valid (code 0); key_held drops only 1000 cycles after the final rising edge.
- Rows 1 and 3 low simultaneously in col2 -> key_code=4'b0110; the row3 key is ignored until full release.
- reset pulsed at cycle 500 of DEBOUNCE -> col_n=1110, key_held=0, key_valid=0 immediately; with the key still held, exactly one key_valid follows after re-scan and debounce.
